cpu_mem_responder: RTL and testbench
====================================

Name: cpu_mem_responder

Overview:
- Memory-side responder for the CPU datapath's split instruction/data request interface.
- Accepts instruction fetches and data loads/stores and arbitrates them onto one single-ported backing memory (pmem) with variable latency.
- Returns results with a level-held response that the pipeline can sample on its advance cycle.
- Sits between cpu_datapath and the cache/physical-memory hierarchy.

Parameters:
ADDR_W, 16, address width (lc3b_word)
DATA_W, 16, data width (lc3b_word)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
instruction_request  in  1  fetch request, held high until the CPU advances
instruction_address  in  16  fetch address
instr  out  16  fetched word
instruction_response  out  1  fetch result valid (level, see HOLD)
data_request  in  1  load/store request, held until the CPU advances
write_enable  in  1  1 = store, 0 = load
mem_address  in  16  data address
mem_byte_enable  in  2  store byte lanes
write_data  in  16  store data
mem_rdata  out  16  load result
data_response  out  1  data result valid (level)
pmem_read  out  1  backing read strobe
pmem_write  out  1  backing write strobe
pmem_address  out  16  backing address
pmem_wdata  out  16  backing write data
pmem_byte_enable  out  2  backing byte lanes
pmem_rdata  in  16  backing read data
pmem_resp  in  1  backing transaction complete, 1-cycle pulse

Behaviour:
- Reset (async): all outputs 0, FSM IDLE, both hold flags clear, captured tags cleared. Any pmem_resp still in flight after reset is ignored.
- FSM states: IDLE, I_ACC, D_ACC.
- Per port, "pending" = request high and the port's hold not satisfying it.
- IDLE:
  - If D pending, go to D_ACC (data has priority over fetch).
  - Else if I pending, go to I_ACC.
  - Grant captures the address, plus write_enable/write_data/mem_byte_enable for D.
- I_ACC:
  - pmem_read=1, pmem_byte_enable=2'b11, pmem_address = captured address.
  - On pmem_resp:
    - If instruction_request is still high and instruction_address equals the capture: register instr <= pmem_rdata and set I hold.
    - Otherwise discard the result.
  - Return to IDLE either way.
- D_ACC:
  - Store: pmem_write=1 with the captured wdata and byte_enable forwarded unmodified (2'b00 still completes).
  - Load: pmem_read=1, byte_enable=2'b11.
  - On pmem_resp with request, address and write_enable all unchanged: set D hold; for a load, register mem_rdata <= pmem_rdata.
  - Otherwise discard the result.
  - Return to IDLE.
- pmem strobes stay stable for the whole access state and deassert the cycle after pmem_resp.
- HOLD (per port):
  - instruction_response / data_response = hold flag, registered.
  - The flag is set the cycle after pmem_resp and stays high while the request stays high with the same address (and the same write_enable for D). The data output is stable throughout.
  - Hold clears the cycle after the request drops or any tag mismatches; the response falls in that same cycle.
  - A new address with the request still high clears the hold and becomes pending.
- Latency: earliest response is 2 cycles after the request (grant cycle, 1-cycle pmem), i.e. pmem latency + 1.
- Coherence: a D store completion whose captured address equals the I hold address clears the I hold in the same cycle the D hold sets. The fetch is then re-issued.
- Simultaneous events:
  - Both ports pending in IDLE: D is granted, I waits.
  - Holds never occupy pmem, so one port can hold while the other accesses.
- Mid-access reset: strobes drop asynchronously and the FSM goes to IDLE.
- Backpressure: starvation of I is impossible because the CPU cannot issue a new D request until it advances, which requires instruction_response.

Decomposition:
- Shared package lc3b_types: lc3b_word (existing) and a new typedef lc3b_mem_resp_state {IDLE, I_ACC, D_ACC}.
- One sub-module, resp_hold: it holds the hold flag, captured tag, and data register plus the compare logic, and is instantiated once per port.

Test Plan:
- Fetch x0100, pmem returns x1234 after 3 cycles -> pmem_read one access; instr=x1234 and instruction_response=1 from cycle 4 until the request drops, then 0 the next cycle.
- Fetch and load x2000 requested in the same cycle -> D_ACC first (pmem_address=x2000), then I_ACC; both responses held concurrently.
- Store x00FF to x3000 with mem_byte_enable=2'b01 -> pmem_write=1, pmem_byte_enable=2'b01, pmem_wdata=x00FF; data_response=1 and mem_rdata unchanged.
- I held at x0100, then a store to x0100 completes -> instruction_response drops, a new I_ACC to x0100 follows, and the new word is returned.
- Fetch address changes x0100 to x0102 during I_ACC -> the old result is discarded, no response, and x0102 is fetched next.
- rst asserted mid D_ACC -> pmem_write falls without waiting for clk; all outputs are 0 and a later stale pmem_resp causes no response.

Source files
------------

// File: rtl/cpu_mem_responder_pkg.sv
// Shared LC-3b types for the memory responder slice: the machine word and
// the responder's arbitration state.
package lc3b_types;

   typedef logic [15:0] lc3b_word;

   typedef enum logic [1:0] {
      IDLE,
      I_ACC,
      D_ACC
   } lc3b_mem_resp_state;

endpackage

// File: rtl/cpu_mem_responder_hold.sv
// Per-port response holder: captures the request tag when the port is
// granted, registers the returned word when the access completes with the
// same tag still presented, and keeps the response level high only while
// the CPU keeps presenting that same tag.
module resp_hold #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              request,
   input  logic [ADDR_W-1:0] address,
   input  logic              write_enable,
   input  logic              grant,
   input  logic              complete,
   input  logic              capture_data,
   input  logic [DATA_W-1:0] rdata,
   input  logic              invalidate,
   output logic              pending,
   output logic              hit,
   output logic              hold,
   output logic [ADDR_W-1:0] tag_address,
   output logic [DATA_W-1:0] data
);
   import lc3b_types::*;

   logic tag_write;
   logic match;

   // Tag compare against what was captured at grant; a completion only
   // counts if the CPU is still asking for exactly that access.
   always_comb begin
      match   = (address == tag_address) && (write_enable == tag_write);
      hit     = complete && request && match;
      pending = request && !(hold && match);
   end

   // Capture the request tag at grant time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_address <= '0;
         tag_write   <= 1'b0;
      end else if (grant) begin
         tag_address <= address;
         tag_write   <= write_enable;
      end
   end

   // Hold flag: set on a matching completion, kept while the tag is still
   // presented, dropped by a tag change, request drop or coherence kill.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold <= 1'b0;
      end else if (hit) begin
         hold <= 1'b1;
      end else if (invalidate) begin
         hold <= 1'b0;
      end else begin
         hold <= hold && request && match;
      end
   end

   // Result word: only loaded on a matching completion that returns data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data <= '0;
      end else if (hit && capture_data) begin
         data <= rdata;
      end
   end

endmodule

// File: rtl/cpu_mem_responder.sv
// Arbitrates the CPU's instruction-fetch and data ports onto one
// single-ported backing memory. Data wins ties; each port's result is held
// as a level until the CPU moves on.
module cpu_mem_responder #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instruction_request,
   input  logic [ADDR_W-1:0] instruction_address,
   output logic [DATA_W-1:0] instr,
   output logic              instruction_response,
   input  logic              data_request,
   input  logic              write_enable,
   input  logic [ADDR_W-1:0] mem_address,
   input  logic [1:0]        mem_byte_enable,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              data_response,
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [DATA_W-1:0] pmem_wdata,
   output logic [1:0]        pmem_byte_enable,
   input  logic [DATA_W-1:0] pmem_rdata,
   input  logic              pmem_resp
);
   import lc3b_types::*;

   lc3b_mem_resp_state state, next_state;

   logic              grant_i, grant_d;
   logic              i_pending, d_pending;
   logic              i_hit, d_hit;
   logic              i_complete, d_complete;
   logic              i_invalidate;
   logic [ADDR_W-1:0] i_tag_address, d_tag_address;
   logic              d_store;
   logic [DATA_W-1:0] d_wdata;
   logic [1:0]        d_be;

   assign i_complete = pmem_resp && (state == I_ACC);
   assign d_complete = pmem_resp && (state == D_ACC);

   // A store landing on the word the fetch port is holding makes that
   // fetched copy stale, so the fetch must be redone.
   assign i_invalidate = d_hit && d_store && (d_tag_address == i_tag_address);

   resp_hold #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_i_hold (
      .clk          (clk),
      .rst          (rst),
      .request      (instruction_request),
      .address      (instruction_address),
      .write_enable (1'b0),
      .grant        (grant_i),
      .complete     (i_complete),
      .capture_data (1'b1),
      .rdata        (pmem_rdata),
      .invalidate   (i_invalidate),
      .pending      (i_pending),
      .hit          (i_hit),
      .hold         (instruction_response),
      .tag_address  (i_tag_address),
      .data         (instr)
   );

   resp_hold #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_d_hold (
      .clk          (clk),
      .rst          (rst),
      .request      (data_request),
      .address      (mem_address),
      .write_enable (write_enable),
      .grant        (grant_d),
      .complete     (d_complete),
      .capture_data (!d_store),
      .rdata        (pmem_rdata),
      .invalidate   (1'b0),
      .pending      (d_pending),
      .hit          (d_hit),
      .hold         (data_response),
      .tag_address  (d_tag_address),
      .data         (mem_rdata)
   );

   // Store payload captured with the data grant so pmem sees stable values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d_store <= 1'b0;
         d_wdata <= '0;
         d_be    <= 2'b00;
      end else if (grant_d) begin
         d_store <= write_enable;
         d_wdata <= write_data;
         d_be    <= mem_byte_enable;
      end
   end

   // Arbitration state register; reset drops any access immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Grant selection and pmem strobes, decoded purely from the state so the
   // strobes are steady for the whole access.
   always_comb begin
      next_state       = state;
      grant_i          = 1'b0;
      grant_d          = 1'b0;
      pmem_read        = 1'b0;
      pmem_write       = 1'b0;
      pmem_address     = '0;
      pmem_wdata       = '0;
      pmem_byte_enable = 2'b00;
      case (state)
         IDLE: begin
            if (d_pending) begin
               grant_d    = 1'b1;
               next_state = D_ACC;
            end else if (i_pending) begin
               grant_i    = 1'b1;
               next_state = I_ACC;
            end
         end
         I_ACC: begin
            pmem_read        = 1'b1;
            pmem_byte_enable = 2'b11;
            pmem_address     = i_tag_address;
            if (pmem_resp) next_state = IDLE;
         end
         D_ACC: begin
            pmem_address = d_tag_address;
            if (d_store) begin
               pmem_write       = 1'b1;
               pmem_wdata       = d_wdata;
               pmem_byte_enable = d_be;
            end else begin
               pmem_read        = 1'b1;
               pmem_byte_enable = 2'b11;
            end
            if (pmem_resp) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: a simple variable-latency pmem
// model, scoreboard queues for pmem accesses and port responses, a monitor
// that pops them as the DUT presents them, and directed timing checks.
module tb_cpu_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        instruction_request;
   logic [15:0] instruction_address;
   logic [15:0] instr;
   logic        instruction_response;
   logic        data_request;
   logic        write_enable;
   logic [15:0] mem_address;
   logic [1:0]  mem_byte_enable;
   logic [15:0] write_data;
   logic [15:0] mem_rdata;
   logic        data_response;
   logic        pmem_read;
   logic        pmem_write;
   logic [15:0] pmem_address;
   logic [15:0] pmem_wdata;
   logic [1:0]  pmem_byte_enable;
   logic [15:0] pmem_rdata;
   logic        pmem_resp;

   int checks = 0;
   int passes = 0;
   int lat    = 1;

   logic [35:0] exp_acc_q[$];
   logic [15:0] exp_i_q[$];
   logic [15:0] exp_d_q[$];
   logic [15:0] rdq[$];

   cpu_mem_responder dut (
      .clk                  (clk),
      .rst                  (rst),
      .instruction_request  (instruction_request),
      .instruction_address  (instruction_address),
      .instr                (instr),
      .instruction_response (instruction_response),
      .data_request         (data_request),
      .write_enable         (write_enable),
      .mem_address          (mem_address),
      .mem_byte_enable      (mem_byte_enable),
      .write_data           (write_data),
      .mem_rdata            (mem_rdata),
      .data_response        (data_response),
      .pmem_read            (pmem_read),
      .pmem_write           (pmem_write),
      .pmem_address         (pmem_address),
      .pmem_wdata           (pmem_wdata),
      .pmem_byte_enable     (pmem_byte_enable),
      .pmem_rdata           (pmem_rdata),
      .pmem_resp            (pmem_resp)
   );

   // clock
   always #5 clk = ~clk;

   function automatic logic [35:0] acc(input logic rd, input logic wr, input logic [1:0] be,
                                       input logic [15:0] addr, input logic [15:0] wd);
      return {rd, wr, be, addr, wd};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // which: 0 = instruction_response, 1 = data_response, 2 = pmem_write
   task automatic wait_high(input int which, input int budget, input string name);
      int n;
      bit seen;
      n = 0;
      seen = 1'b0;
      while (n < budget && !seen) begin
         @(negedge clk);
         case (which)
            0: seen = instruction_response;
            1: seen = data_response;
            default: seen = pmem_write;
         endcase
         n++;
      end
      checks++;
      if (seen) passes++;
      else $display("FAIL %s: still low after %0d cycles, expected high", name, budget);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // pmem model: answers each access after lat cycles with the next queued word
   initial begin
      pmem_resp  = 1'b0;
      pmem_rdata = 16'h0000;
      forever begin
         @(negedge clk);
         if (pmem_read || pmem_write) begin
            repeat (lat - 1) @(negedge clk);
            if (pmem_read) pmem_rdata = (rdq.size() > 0) ? rdq.pop_front() : 16'hDEAD;
            pmem_resp = 1'b1;
            @(posedge clk);
            #1 pmem_resp = 1'b0;
         end
      end
   end

   // monitor: pops the scoreboard whenever an access starts or a response rises
   initial begin
      logic prev_strobe, prev_i, prev_d;
      logic [35:0] e;
      logic [15:0] w;
      prev_strobe = 1'b0;
      prev_i      = 1'b0;
      prev_d      = 1'b0;
      forever begin
         @(negedge clk);
         if ((pmem_read || pmem_write) && !prev_strobe) begin
            if (exp_acc_q.size() == 0) begin
               checks++;
               $display("FAIL pmem_access: unexpected access addr %0h, none required", pmem_address);
            end else begin
               e = exp_acc_q.pop_front();
               check("pmem_access", {pmem_read, pmem_write, pmem_byte_enable, pmem_address, pmem_wdata}, e);
            end
         end
         if (instruction_response && !prev_i) begin
            if (exp_i_q.size() == 0) begin
               checks++;
               $display("FAIL i_response: unexpected response instr %0h, none required", instr);
            end else begin
               w = exp_i_q.pop_front();
               check("i_response_instr", instr, w);
            end
         end
         if (data_response && !prev_d) begin
            if (exp_d_q.size() == 0) begin
               checks++;
               $display("FAIL d_response: unexpected response mem_rdata %0h, none required", mem_rdata);
            end else begin
               w = exp_d_q.pop_front();
               check("d_response_rdata", mem_rdata, w);
            end
         end
         prev_strobe = pmem_read || pmem_write;
         prev_i      = instruction_response;
         prev_d      = data_response;
      end
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog expired");
   end

   // directed stimulus
   initial begin
      rst                 = 1'b1;
      instruction_request = 1'b0;
      instruction_address = 16'h0000;
      data_request        = 1'b0;
      write_enable        = 1'b0;
      mem_address         = 16'h0000;
      mem_byte_enable     = 2'b00;
      write_data          = 16'h0000;
      repeat (3) @(posedge clk);
      #2;
      check("reset_strobes_resp", {pmem_read, pmem_write, instruction_response, data_response}, 4'b0000);
      check("reset_data_out", {instr, mem_rdata}, 32'h0);
      check("reset_pmem_bus", {pmem_address, pmem_wdata, pmem_byte_enable}, 34'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle(2);

      // S1: single fetch, 3-cycle pmem; response from cycle 4
      lat = 3;
      rdq.push_back(16'h1234);
      exp_acc_q.push_back(acc(1'b1, 1'b0, 2'b11, 16'h0100, 16'h0000));
      exp_i_q.push_back(16'h1234);
      instruction_request = 1'b1;
      instruction_address = 16'h0100;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("s1_no_early_resp", instruction_response, 1'b0);
      end
      @(negedge clk);
      check("s1_resp_cycle4", instruction_response, 1'b1);
      check("s1_instr", instr, 16'h1234);
      repeat (3) @(negedge clk);
      check("s1_resp_held", {instruction_response, pmem_read}, 2'b10);
      @(posedge clk);
      #1 instruction_request = 1'b0;
      @(negedge clk);
      check("s1_resp_until_edge", instruction_response, 1'b1);
      @(negedge clk);
      check("s1_resp_drops", instruction_response, 1'b0);
      idle(2);

      // S2: fetch and load in the same cycle; data first, both held together
      lat = 1;
      rdq.push_back(16'hAAAA);
      rdq.push_back(16'hBBBB);
      exp_acc_q.push_back(acc(1'b1, 1'b0, 2'b11, 16'h2000, 16'h0000));
      exp_acc_q.push_back(acc(1'b1, 1'b0, 2'b11, 16'h0200, 16'h0000));
      exp_d_q.push_back(16'hAAAA);
      exp_i_q.push_back(16'hBBBB);
      instruction_request = 1'b1;
      instruction_address = 16'h0200;
      data_request        = 1'b1;
      write_enable        = 1'b0;
      mem_address         = 16'h2000;
      wait_high(0, 20, "s2_i_resp_timeout");
      check("s2_both_held", {instruction_response, data_response}, 2'b11);
      check("s2_words", {instr, mem_rdata}, 32'hBBBB_AAAA);
      @(posedge clk);
      #1;
      instruction_request = 1'b0;
      data_request        = 1'b0;
      idle(2);

      // S3: byte store, mem_rdata keeps the previous load value
      lat = 2;
      exp_acc_q.push_back(acc(1'b0, 1'b1, 2'b01, 16'h3000, 16'h00FF));
      exp_d_q.push_back(16'hAAAA);
      data_request    = 1'b1;
      write_enable    = 1'b1;
      mem_address     = 16'h3000;
      mem_byte_enable = 2'b01;
      write_data      = 16'h00FF;
      wait_high(1, 20, "s3_d_resp_timeout");
      check("s3_rdata_unchanged", mem_rdata, 16'hAAAA);
      @(posedge clk);
      #1 data_request = 1'b0;
      idle(2);

      // S4: store to the held fetch address kills the fetch hold and refetches
      lat = 1;
      rdq.push_back(16'h1111);
      exp_acc_q.push_back(acc(1'b1, 1'b0, 2'b11, 16'h0100, 16'h0000));
      exp_i_q.push_back(16'h1111);
      instruction_request = 1'b1;
      instruction_address = 16'h0100;
      wait_high(0, 20, "s4_first_fetch_timeout");
      @(posedge clk);
      #1;
      rdq.push_back(16'h2222);
      exp_acc_q.push_back(acc(1'b0, 1'b1, 2'b11, 16'h0100, 16'h5555));
      exp_acc_q.push_back(acc(1'b1, 1'b0, 2'b11, 16'h0100, 16'h0000));
      exp_d_q.push_back(16'hAAAA);
      exp_i_q.push_back(16'h2222);
      data_request    = 1'b1;
      write_enable    = 1'b1;
      mem_address     = 16'h0100;
      mem_byte_enable = 2'b11;
      write_data      = 16'h5555;
      wait_high(1, 20, "s4_store_timeout");
      check("s4_i_hold_killed", instruction_response, 1'b0);
      wait_high(0, 20, "s4_refetch_timeout");
      check("s4_refetch_word", instr, 16'h2222);
      @(posedge clk);
      #1;
      instruction_request = 1'b0;
      data_request        = 1'b0;
      write_enable        = 1'b0;
      idle(2);

      // S5: fetch address changes mid-access; stale word discarded
      lat = 3;
      rdq.push_back(16'h7777);
      rdq.push_back(16'h8888);
      exp_acc_q.push_back(acc(1'b1, 1'b0, 2'b11, 16'h0100, 16'h0000));
      exp_acc_q.push_back(acc(1'b1, 1'b0, 2'b11, 16'h0102, 16'h0000));
      exp_i_q.push_back(16'h8888);
      instruction_request = 1'b1;
      instruction_address = 16'h0100;
      @(posedge clk);
      #1 instruction_address = 16'h0102;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("s5_no_stale_resp", instruction_response, 1'b0);
      end
      wait_high(0, 20, "s5_refetch_timeout");
      check("s5_new_word", instr, 16'h8888);
      @(posedge clk);
      #1 instruction_request = 1'b0;
      idle(2);

      // S6: reset during a store drops strobes without a clock edge
      lat = 4;
      exp_acc_q.push_back(acc(1'b0, 1'b1, 2'b11, 16'h4000, 16'h1234));
      data_request    = 1'b1;
      write_enable    = 1'b1;
      mem_address     = 16'h4000;
      mem_byte_enable = 2'b11;
      write_data      = 16'h1234;
      wait_high(2, 20, "s6_store_start_timeout");
      #2;
      rst          = 1'b1;
      data_request = 1'b0;
      write_enable = 1'b0;
      #1;
      check("s6_async_write_drop", {pmem_read, pmem_write}, 2'b00);
      check("s6_reset_outputs", {instr, mem_rdata, instruction_response, data_response}, 34'h0);
      check("s6_reset_pmem_bus", {pmem_address, pmem_wdata, pmem_byte_enable}, 34'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check("s6_stale_resp_ignored", {data_response, instruction_response, pmem_write}, 3'b000);
      end

      check("end_acc_queue_empty", exp_acc_q.size(), 0);
      check("end_i_queue_empty", exp_i_q.size(), 0);
      check("end_d_queue_empty", exp_d_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
